// File: rtl/mul_pkg.sv
// Shared definitions for the two-requester sign-magnitude multiplier arbiter.
package mul_pkg;
    localparam int OP_W  = 3;
    localparam int RES_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/sm_mul3.sv
// Combinational 3-bit sign-magnitude multiplier producing a 5-bit sign-magnitude product.
module sm_mul3
    import mul_pkg::*;
(
    input  logic [OP_W-1:0]  a,
    input  logic [OP_W-1:0]  b,
    output logic [RES_W-1:0] r,
    output logic             sf,
    output logic             zf,
    output logic             dzf
);
    logic [3:0] mag;

    assign mag = {2'b00, a[1:0]} * {2'b00, b[1:0]};
    assign zf  = (mag == 4'd0);
    // A zero magnitude always yields +0, so negative-zero operands never leak a sign.
    assign sf  = (a[2] ^ b[2]) & ~zf;
    assign r   = {sf, mag};
    assign dzf = 1'b0;
endmodule

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one sign-magnitude multiplier between two requesters.
module mul_arbiter
    import mul_pkg::*;
#(
    parameter bit RR_INIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OP_W-1:0]  req0_a,
    input  logic [OP_W-1:0]  req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OP_W-1:0]  req1_a,
    input  logic [OP_W-1:0]  req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [RES_W-1:0] rsp_r,
    output logic             rsp_sf,
    output logic             rsp_zf,
    output logic             rsp_dzf,
    output state_t           dbg_state
);
    // Handshake: a transfer occurs on a rising edge where valid and ready are both 1.
    // Request ready is high only in IDLE for the granted requester; rsp_valid stays
    // high in DONE with rsp_* held stable until rsp_ready.
    state_t          state;
    logic            prio;
    logic            op_id;
    logic [OP_W-1:0] op_a;
    logic [OP_W-1:0] op_b;
    logic            grant0;
    logic            grant1;
    logic [RES_W-1:0] mul_r;
    logic            mul_sf;
    logic            mul_zf;
    logic            mul_dzf;

    assign grant0     = req0_valid & (~req1_valid | (prio == 1'b0));
    assign grant1     = req1_valid & (~req0_valid | (prio == 1'b1));
    assign req0_ready = (state == IDLE) & ~rst & grant0;
    assign req1_ready = (state == IDLE) & ~rst & grant1;
    assign dbg_state  = state;

    sm_mul3 u_mul (
        .a   (op_a),
        .b   (op_b),
        .r   (mul_r),
        .sf  (mul_sf),
        .zf  (mul_zf),
        .dzf (mul_dzf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            prio      <= RR_INIT;
            op_id     <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_r     <= '0;
            rsp_sf    <= 1'b0;
            rsp_zf    <= 1'b0;
            rsp_dzf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0) begin
                        op_a  <= req0_a;
                        op_b  <= req0_b;
                        op_id <= 1'b0;
                        prio  <= 1'b1;
                        state <= EXEC;
                    end else if (grant1) begin
                        op_a  <= req1_a;
                        op_b  <= req1_b;
                        op_id <= 1'b1;
                        prio  <= 1'b0;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_r     <= mul_r;
                    rsp_sf    <= mul_sf;
                    rsp_zf    <= mul_zf;
                    rsp_dzf   <= mul_dzf;
                    rsp_id    <= op_id;
                    rsp_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter: vector table, directed corner sequences, random traffic.
module tb_mul_arbiter;
    import mul_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [2:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic       req0_ready, req1_ready;
    logic       rsp_valid, rsp_id, rsp_sf, rsp_zf, rsp_dzf;
    logic       rsp_ready = 1'b0;
    logic [4:0] rsp_r;
    state_t     dbg_state;

    mul_arbiter #(.RR_INIT(1'b0)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_r(rsp_r),
        .rsp_sf(rsp_sf), .rsp_zf(rsp_zf), .rsp_dzf(rsp_dzf), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Response packing used everywhere: {id, r[4:0], sf, zf, dzf}
    function automatic logic [8:0] model(input logic id, input logic [2:0] a, input logic [2:0] b);
        int ma, mb, prod;
        bit neg;
        logic [4:0] r;
        ma   = int'(a[1:0]);
        mb   = int'(b[1:0]);
        prod = ma * mb;
        neg  = (a[2] != b[2]) && (prod != 0);
        r    = neg ? 5'(prod + 16) : 5'(prod);
        return {id, r, neg, (prod == 0), 1'b0};
    endfunction

    function automatic logic [8:0] rsp_now();
        return {rsp_id, rsp_r, rsp_sf, rsp_zf, rsp_dzf};
    endfunction

    // Reference model state for the monitor
    bit         mon_en = 1'b0;
    bit         ptr_m = 1'b0;
    int         age = 0;
    logic [8:0] exp_q[$];
    int         grants[$];
    logic       e0, e1, idle_m;

    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() > 0) age++;
            idle_m = (exp_q.size() == 0);
            e0 = idle_m && req0_valid && (!req1_valid || ptr_m == 1'b0);
            e1 = idle_m && req1_valid && (!req0_valid || ptr_m == 1'b1);
            chk("mon_ready0", req0_ready, e0);
            chk("mon_ready1", req1_ready, e1);
            if (exp_q.size() > 0) begin
                chk("mon_rsp_valid", rsp_valid, (age >= 2));
                if (rsp_valid) chk("mon_rsp", rsp_now(), exp_q[0]);
                if (rsp_valid && rsp_ready && age >= 2) void'(exp_q.pop_front());
            end else begin
                chk("mon_rsp_valid_idle", rsp_valid, 1'b0);
            end
            if (req0_valid && req0_ready) grants.push_back(0);
            if (req1_valid && req1_ready) grants.push_back(1);
            if (e0) begin
                exp_q.push_back(model(1'b0, req0_a, req0_b));
                ptr_m = 1'b1;
                age = 0;
            end else if (e1) begin
                exp_q.push_back(model(1'b1, req1_a, req1_b));
                ptr_m = 1'b0;
                age = 0;
            end
        end
    end

    task automatic do_reset();
        mon_en = 1'b0;
        rst = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        repeat (2) begin
            @(posedge clk); #2;
            chk("rst_ready0", req0_ready, 1'b0);
            chk("rst_ready1", req1_ready, 1'b0);
        end
        chk("rst_rsp", {rsp_valid, rsp_now()}, 10'd0);
        chk("rst_state", dbg_state, IDLE);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        ptr_m = 1'b0;
        age = 0;
        exp_q.delete();
        grants.delete();
    endtask

    task automatic do_op(input logic id, input logic [2:0] a, input logic [2:0] b,
                         output logic [8:0] got, output int lat);
        int w;
        w = 0;
        got = 'x;
        lat = 0;
        if (id == 1'b0) begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
        else            begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
        #1;
        while (!(id ? req1_ready : req0_ready) && w < 20) begin
            @(posedge clk); #2;
            w++;
        end
        if (w >= 20) begin
            chk("grant_timeout", 1'b1, 1'b0);
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        got = rsp_now();
    endtask

    typedef struct {
        logic       id;
        logic [2:0] a;
        logic [2:0] b;
        logic [8:0] exp;
    } vec_t;

    vec_t       vecs[5];
    logic [8:0] got;
    int         lat;

    initial begin
        vecs[0] = '{1'b0, 3'b011, 3'b111, {1'b0, 5'b11001, 1'b1, 1'b0, 1'b0}};
        vecs[1] = '{1'b1, 3'b100, 3'b011, {1'b1, 5'b00000, 1'b0, 1'b1, 1'b0}};
        vecs[2] = '{1'b1, 3'b110, 3'b110, {1'b1, 5'b00100, 1'b0, 1'b0, 1'b0}};
        vecs[3] = '{1'b0, 3'b010, 3'b011, {1'b0, 5'b00110, 1'b0, 1'b0, 1'b0}};
        vecs[4] = '{1'b1, 3'b111, 3'b001, {1'b1, 5'b10011, 1'b1, 1'b0, 1'b0}};

        do_reset();
        rsp_ready = 1'b1;

        // Directed vectors with latency check
        for (int i = 0; i < 5; i++) begin
            do_op(vecs[i].id, vecs[i].a, vecs[i].b, got, lat);
            chk($sformatf("vec%0d_rsp", i), got, vecs[i].exp);
            chk($sformatf("vec%0d_latency", i), lat, 2);
        end

        // Exhaustive operand sweep through requester 0
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                do_op(1'b0, 3'(a), 3'(b), got, lat);
                chk($sformatf("sweep_%0d_%0d", a, b), got, model(1'b0, 3'(a), 3'(b)));
            end
        end

        // Both requesters held valid: alternating grants
        do_reset();
        rsp_ready = 1'b1;
        mon_en = 1'b1;
        req0_a = 3'b001; req0_b = 3'b010;
        req1_a = 3'b101; req1_b = 3'b011;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        repeat (13) @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        mon_en = 1'b0;
        chk("rr_grant_count", (grants.size() >= 4), 1'b1);
        for (int i = 0; i < 4 && i < grants.size(); i++)
            chk($sformatf("rr_grant%0d", i), grants[i], i % 2);

        // Stall in DONE for 5 cycles
        do_reset();
        rsp_ready = 1'b0;
        do_op(1'b1, 3'b111, 3'b011, got, lat);
        chk("stall_first_rsp", got, {1'b1, 5'b11001, 1'b1, 1'b0, 1'b0});
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        repeat (5) begin
            #1;
            chk("stall_rsp", rsp_now(), {1'b1, 5'b11001, 1'b1, 1'b0, 1'b0});
            chk("stall_valid", rsp_valid, 1'b1);
            chk("stall_ready0", req0_ready, 1'b0);
            chk("stall_ready1", req1_ready, 1'b0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #2;
        chk("stall_release_valid", rsp_valid, 1'b0);
        chk("stall_release_state", dbg_state, IDLE);
        chk("stall_next_ready0", req0_ready, 1'b1);
        chk("stall_next_ready1", req1_ready, 1'b0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Reset during EXEC abandons the operation
        do_reset();
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 3'b011; req0_b = 3'b011;
        #1;
        chk("abort_grant", req0_ready, 1'b1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        chk("abort_in_exec", dbg_state, EXEC);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_state", dbg_state, IDLE);
        chk("abort_rsp_valid", rsp_valid, 1'b0);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk("abort_ptr_ready0", req0_ready, 1'b1);
        chk("abort_ptr_ready1", req1_ready, 1'b0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            chk("abort_no_stale", rsp_valid, 1'b0);
        end

        // Random traffic against the reference model
        do_reset();
        mon_en = 1'b1;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            req0_valid = ($urandom_range(0, 9) < 6);
            req1_valid = ($urandom_range(0, 9) < 6);
            req0_a = 3'($urandom_range(0, 7));
            req0_b = 3'($urandom_range(0, 7));
            req1_a = 3'($urandom_range(0, 7));
            req1_b = 3'($urandom_range(0, 7));
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        mon_en = 1'b0;
        chk("random_grants_seen", (grants.size() > 50), 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
